bp_cfg_boot_sequencer: RTL and testbench
========================================

Name: bp_cfg_boot_sequencer

Overview:
- Boot-time stage that directly consumes the selected processor configuration (cc_x_dim/cc_y_dim/ic_y_dim of the active bp_proc_param_s).
- Walks every core tile and issues config-link writes: freeze, core id, cord, CCE mode. A second pass then unfreezes all tiles.
- Sits between the top-level reset/start logic and the config-link network feeding each tile.
- Bounds outstanding writes with a credit counter and drains responses before each pass boundary.

Parameters:
- cc_x_dim_p, 2, core columns (from selected config).
- cc_y_dim_p, 1, core rows.
- ic_y_dim_p, 1, I/O rows above cores; added to the cord y coordinate.
- cfg_addr_width_p, 16, config register address width.
- cfg_data_width_p, 32, config write data width.
- max_outstanding_p, 4, maximum unacknowledged writes (at least 1).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse that begins the sequence; sampled only in IDLE
- cfg_v_o  out  1  write valid
- cfg_ready_i  in  1  write accepted when cfg_v_o & cfg_ready_i
- cfg_dst_o  out  clog2(cc_x_dim_p*cc_y_dim_p)  destination core index
- cfg_addr_o  out  cfg_addr_width_p  register address
- cfg_data_o  out  cfg_data_width_p  write data
- cfg_resp_v_i  in  1  write acknowledge; one per accepted write
- cfg_resp_ready_o  out  1  always 1 outside reset
- busy_o  out  1  sequence in progress
- done_o  out  1  sticky; all tiles configured and unfrozen
- err_o  out  1  sticky; acknowledge received with zero outstanding

Behaviour:
- Reset: asynchronous, all state cleared. All outputs 0, FSM enters IDLE.
- N = cc_x_dim_p*cc_y_dim_p. For core k: x = k % cc_x_dim_p, y = k / cc_x_dim_p + ic_y_dim_p.
- FSM states: IDLE, CFG, DRAIN_CFG, UNFREEZE, DRAIN_UNF, DONE.
- IDLE: start_i=1 moves to CFG. cfg_v_o rises on the next cycle.
- CFG: core k from 0 to N-1, step s from 0 to 3, each write in order:
  - s0: addr FREEZE, data 1
  - s1: addr CORE_ID, data k
  - s2: addr CORD, data {y,x} (x in the low 8 bits, y in bits 15:8)
  - s3: addr CCE_MODE, data NORMAL
  - After k=N-1, s=3 is accepted, go to DRAIN_CFG.
- DRAIN_CFG: cfg_v_o=0. Wait until outstanding==0, then go to UNFREEZE.
- UNFREEZE: one write per core, k from 0 to N-1: addr FREEZE, data 0. After the last is accepted, go to DRAIN_UNF.
- DRAIN_UNF: wait until outstanding==0, then go to DONE.
- DONE: done_o=1, busy_o=0. start_i is ignored until reset.
- Handshake:
  - cfg_v_o is asserted only when outstanding < max_outstanding_p.
  - While cfg_v_o=1 and cfg_ready_i=0, dst/addr/data are held stable.
  - The step/core counters advance only on acceptance.
- Outstanding counter, width clog2(max_outstanding_p+1):
  - +1 on accept, -1 on response.
  - Accept and response in the same cycle leave it unchanged.
  - At max_outstanding_p, cfg_v_o drops the same cycle.
- A response arriving with outstanding==0 sets err_o, and the counter does not underflow (stays 0).
- busy_o=1 in CFG, DRAIN_CFG, UNFREEZE and DRAIN_UNF.
- start_i while busy is ignored.
- Reset asserted mid-sequence aborts immediately. Tile state is not rolled back; a new start is required.
- Total accepted writes = 5N. done_o asserts the cycle after the final response is counted.

Decomposition:
- Shared package bp_cfg_link_pkg:
  - address constants: e_cfg_freeze=16'h0001, e_cfg_core_id=16'h0002, e_cfg_cord=16'h0003, e_cfg_cce_mode=16'h0004
  - CCE mode enum: e_cce_mode_uncached=0, e_cce_mode_normal=1
  - FSM state enum bp_cfg_boot_state_e
- Sub-module bp_cfg_credit_counter: up/down counter with full, empty and underflow-error flags.

Test Plan:
- N=2, ready=1, response 1 cycle after accept, start pulse at cycle 5:
  - 10 writes in order: (0,F,1) (0,ID,0) (0,CORD,0x0100) (0,MODE,1) (1,F,1) (1,ID,1) (1,CORD,0x0101) (1,MODE,1) (0,F,0) (1,F,0)
  - done_o=1 one cycle after the 10th response.
- Responses withheld, max_outstanding_p=4: exactly 4 accepts, then cfg_v_o=0. Releasing one response leads to exactly one more accept.
- cfg_ready_i=0 for 7 cycles on write 3: dst/addr/data held; the sequence continues unchanged afterward.
- Spurious cfg_resp_v_i in IDLE: err_o=1 sticky, counter stays 0, no writes issued.
- reset_n_i=0 mid-CFG after write 2: all outputs 0 immediately. A new start restarts at (0,F,1).
- cc_x_dim_p=2, cc_y_dim_p=2, ic_y_dim_p=1: core 3 cord = 0x0201. 20 total writes. start_i during DRAIN_CFG is ignored.

Source files
------------

// File: rtl/bp_cfg_link_pkg.sv
// Shared config-link definitions used by the boot sequencer.
//   - Config register addresses written to each core tile.
//   - CCE mode encoding carried in the CCE_MODE write.
//   - Boot sequencer FSM state encoding.
package bp_cfg_link_pkg;

  localparam logic [15:0] e_cfg_freeze   = 16'h0001;
  localparam logic [15:0] e_cfg_core_id  = 16'h0002;
  localparam logic [15:0] e_cfg_cord     = 16'h0003;
  localparam logic [15:0] e_cfg_cce_mode = 16'h0004;

  typedef enum logic {
    e_cce_mode_uncached = 1'b0,
    e_cce_mode_normal   = 1'b1
  } bp_cce_mode_e;

  typedef enum logic [2:0] {
    e_boot_idle      = 3'd0,
    e_boot_cfg       = 3'd1,
    e_boot_drain_cfg = 3'd2,
    e_boot_unfreeze  = 3'd3,
    e_boot_drain_unf = 3'd4,
    e_boot_done      = 3'd5
  } bp_cfg_boot_state_e;

endpackage

// File: rtl/bp_cfg_credit_counter.sv
// Outstanding-write counter for the config link.
//   inc_i   : a write was accepted this cycle
//   dec_i   : a write acknowledge arrived this cycle
//   full_o  : count has reached max_p (no further writes may issue)
//   empty_o : count will be zero once this cycle's updates land
//   err_o   : sticky; an acknowledge arrived with nothing outstanding
module bp_cfg_credit_counter #(
  parameter int max_p = 4,
  localparam int cnt_w_lp = $clog2(max_p + 1)
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o,
  output logic err_o
);

  logic [cnt_w_lp-1:0] count_r, count_n;
  logic underflow, down;

  // A stray acknowledge is flagged and otherwise ignored so the count never wraps.
  assign underflow = dec_i && (count_r == '0);
  assign down      = dec_i && !underflow;

  always_comb begin
    count_n = count_r;
    if (inc_i && !down)      count_n = count_r + cnt_w_lp'(1);
    else if (!inc_i && down) count_n = count_r - cnt_w_lp'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= '0;
      err_o   <= 1'b0;
    end else begin
      count_r <= count_n;
      if (underflow) err_o <= 1'b1;
    end
  end

  assign full_o  = (count_r == cnt_w_lp'(max_p));
  // Look-ahead so the drain states can leave in the cycle of the last ack.
  assign empty_o = (count_n == '0);

endmodule

// File: rtl/bp_cfg_boot_sequencer.sv
// Boot-time config-link sequencer.
// Pass 1 writes FREEZE=1, CORE_ID, CORD, CCE_MODE=NORMAL to every core tile;
// pass 2 writes FREEZE=0 to every tile. Outstanding writes are credit-bounded
// and fully drained before each pass boundary.
//   clk_i/reset_n_i    : clock, async active-low reset
//   start_i            : begin the sequence (honoured only in IDLE)
//   cfg_v_o/ready_i    : write handshake, with dst/addr/data payload
//   cfg_resp_v_i       : one acknowledge per accepted write
//   cfg_resp_ready_o   : always 1 outside reset
//   busy_o/done_o/err_o: status; done and err are sticky until reset
module bp_cfg_boot_sequencer
  import bp_cfg_link_pkg::*;
#(
  parameter int cc_x_dim_p        = 2,
  parameter int cc_y_dim_p        = 1,
  parameter int ic_y_dim_p        = 1,
  parameter int cfg_addr_width_p  = 16,
  parameter int cfg_data_width_p  = 32,
  parameter int max_outstanding_p = 4,
  localparam int num_core_lp  = cc_x_dim_p * cc_y_dim_p,
  localparam int dst_width_lp = (num_core_lp > 1) ? $clog2(num_core_lp) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [dst_width_lp-1:0]     cfg_dst_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_resp_v_i,
  output logic                        cfg_resp_ready_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  localparam logic [dst_width_lp-1:0] last_core_lp = dst_width_lp'(num_core_lp - 1);

  bp_cfg_boot_state_e state_r, state_n;
  logic [dst_width_lp-1:0]     core_r;
  logic [1:0]                  step_r;
  logic [7:0]                  x_r, y_r;   // y_r is the core row; ic_y_dim_p added on output
  logic                        accept, last_core, full, drained;
  logic [cfg_data_width_p-1:0] cord_data;

  assign accept    = cfg_v_o & cfg_ready_i;
  assign last_core = (core_r == last_core_lp);

  bp_cfg_credit_counter #(.max_p(max_outstanding_p)) credit (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .inc_i    (accept),
    .dec_i    (cfg_resp_v_i),
    .full_o   (full),
    .empty_o  (drained),
    .err_o    (err_o)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= e_boot_idle;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_boot_idle:      if (start_i) state_n = e_boot_cfg;
      e_boot_cfg:       if (accept && last_core && step_r == 2'd3) state_n = e_boot_drain_cfg;
      e_boot_drain_cfg: if (drained) state_n = e_boot_unfreeze;
      e_boot_unfreeze:  if (accept && last_core) state_n = e_boot_drain_unf;
      e_boot_drain_unf: if (drained) state_n = e_boot_done;
      e_boot_done:      state_n = e_boot_done;
      default:          state_n = e_boot_idle;
    endcase
  end

  always_comb begin
    cord_data       = '0;
    cord_data[15:0] = {y_r + 8'(ic_y_dim_p), x_r};
  end

  // Payload is a pure function of the counters, which only move on acceptance,
  // so it stays stable while a write is back-pressured.
  always_comb begin
    cfg_v_o    = 1'b0;
    cfg_dst_o  = '0;
    cfg_addr_o = '0;
    cfg_data_o = '0;
    unique case (state_r)
      e_boot_cfg: begin
        cfg_v_o   = !full;
        cfg_dst_o = core_r;
        unique case (step_r)
          2'd0: begin
            cfg_addr_o = cfg_addr_width_p'(e_cfg_freeze);
            cfg_data_o = cfg_data_width_p'(1);
          end
          2'd1: begin
            cfg_addr_o = cfg_addr_width_p'(e_cfg_core_id);
            cfg_data_o = cfg_data_width_p'(core_r);
          end
          2'd2: begin
            cfg_addr_o = cfg_addr_width_p'(e_cfg_cord);
            cfg_data_o = cord_data;
          end
          default: begin
            cfg_addr_o = cfg_addr_width_p'(e_cfg_cce_mode);
            cfg_data_o = cfg_data_width_p'(e_cce_mode_normal);
          end
        endcase
      end
      e_boot_unfreeze: begin
        cfg_v_o    = !full;
        cfg_dst_o  = core_r;
        cfg_addr_o = cfg_addr_width_p'(e_cfg_freeze);
      end
      default: ;
    endcase
  end

  // Core/step walk. Counters wrap to zero at the end of pass 1 so pass 2
  // starts again from core 0.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      core_r <= '0;
      step_r <= '0;
      x_r    <= '0;
      y_r    <= '0;
    end else if (accept) begin
      if (state_r == e_boot_unfreeze) begin
        core_r <= last_core ? '0 : core_r + dst_width_lp'(1);
      end else begin
        step_r <= step_r + 2'd1;
        if (step_r == 2'd3) begin
          if (last_core) begin
            core_r <= '0;
            x_r    <= '0;
            y_r    <= '0;
          end else begin
            core_r <= core_r + dst_width_lp'(1);
            if (x_r == 8'(cc_x_dim_p - 1)) begin
              x_r <= '0;
              y_r <= y_r + 8'd1;
            end else begin
              x_r <= x_r + 8'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) cfg_resp_ready_o <= 1'b0;
    else            cfg_resp_ready_o <= 1'b1;
  end

  assign busy_o = (state_r == e_boot_cfg) || (state_r == e_boot_drain_cfg) ||
                  (state_r == e_boot_unfreeze) || (state_r == e_boot_drain_unf);
  assign done_o = (state_r == e_boot_done);

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Bench for bp_cfg_boot_sequencer: instance 0 is a 2x1 core array, instance 1
// a 2x2 array, both with 4 credits and one I/O row.
module tb_bp_cfg_boot_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_n, start, ready, resp_v;
  logic [1:0] v, rrdy, busy, done, err;
  logic [0:0] dst_a;
  logic [1:0] dst_b;
  logic [1:0][15:0] addr;
  logic [1:0][31:0] data;

  bp_cfg_boot_sequencer #(.cc_x_dim_p(2), .cc_y_dim_p(1), .ic_y_dim_p(1),
    .cfg_addr_width_p(16), .cfg_data_width_p(32), .max_outstanding_p(4)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n[0]), .start_i(start[0]), .cfg_v_o(v[0]),
    .cfg_ready_i(ready[0]), .cfg_dst_o(dst_a), .cfg_addr_o(addr[0]), .cfg_data_o(data[0]),
    .cfg_resp_v_i(resp_v[0]), .cfg_resp_ready_o(rrdy[0]), .busy_o(busy[0]),
    .done_o(done[0]), .err_o(err[0]));

  bp_cfg_boot_sequencer #(.cc_x_dim_p(2), .cc_y_dim_p(2), .ic_y_dim_p(1),
    .cfg_addr_width_p(16), .cfg_data_width_p(32), .max_outstanding_p(4)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n[1]), .start_i(start[1]), .cfg_v_o(v[1]),
    .cfg_ready_i(ready[1]), .cfg_dst_o(dst_b), .cfg_addr_o(addr[1]), .cfg_data_o(data[1]),
    .cfg_resp_v_i(resp_v[1]), .cfg_resp_ready_o(rrdy[1]), .busy_o(busy[1]),
    .done_o(done[1]), .err_o(err[1]));

  typedef struct { int dst; int addr; int data; } wr_t;
  typedef struct {
    logic start, rdy, resp, v;
    int dst, addr, data;
    logic busy, done;
  } vec_t;

  int checks = 0, failures = 0;
  int widx[2], pend[2], nacc[2], resp_mode[2], rdy_mode[2], rel[2];
  int stall_at[2], stall_left[2], snap_dst[2], snap_addr[2], snap_data[2];
  logic spur[2];
  vec_t vec[14];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int dst_of(int d);
    return (d == 0) ? int'(dst_a) : int'(dst_b);
  endfunction

  function automatic int ncore(int d);
    return (d == 0) ? 2 : 4;
  endfunction

  // Expected write number idx for instance d: pass 1 is four writes per core,
  // pass 2 one unfreeze per core. Cord y is row + 1 I/O row, x is column.
  function automatic wr_t model(int d, int idx);
    wr_t r;
    int n, k;
    n = ncore(d);
    if (idx < 4 * n) begin
      k = idx / 4;
      r.dst = k;
      case (idx % 4)
        0: begin r.addr = 1; r.data = 1; end
        1: begin r.addr = 2; r.data = k; end
        2: begin r.addr = 3; r.data = ((k / 2 + 1) << 8) | (k % 2); end
        default: begin r.addr = 4; r.data = 1; end
      endcase
    end else begin
      r.dst = idx - 4 * n; r.addr = 1; r.data = 0;
    end
    return r;
  endfunction

  function automatic vec_t mk(logic s, logic r, logic rs, logic ev, int ed, int ea,
                              int edat, logic eb, logic edn);
    vec_t t;
    t.start = s; t.rdy = r; t.resp = rs; t.v = ev; t.dst = ed; t.addr = ea;
    t.data = edat; t.busy = eb; t.done = edn;
    return t;
  endfunction

  // One clock: at the falling edge sample outputs, decide this cycle's
  // response/ready for both instances, and score any write accepted.
  task automatic cyc();
    logic rv, rd;
    wr_t e;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (v[d]) chk("valid_under_credit", int'(pend[d] < 4), 1);
      rv = 1'b0;
      case (resp_mode[d])
        1: rv = (pend[d] > 0);
        2: rv = (pend[d] > 0) && ($urandom_range(0, 1) == 1);
        default: rv = 1'b0;
      endcase
      if (rel[d] > 0 && pend[d] > 0) begin rv = 1'b1; rel[d]--; end
      if (rv) pend[d]--;
      if (spur[d]) begin rv = 1'b1; spur[d] = 1'b0; end
      resp_v[d] = rv;
      rd = (rdy_mode[d] == 1) || (rdy_mode[d] == 2 && $urandom_range(0, 3) != 0);
      if (v[d] && widx[d] == stall_at[d] && stall_left[d] > 0) begin
        if (stall_left[d] == 7) begin
          snap_dst[d] = dst_of(d); snap_addr[d] = int'(addr[d]); snap_data[d] = int'(data[d]);
        end else begin
          chk("hold_dst", dst_of(d), snap_dst[d]);
          chk("hold_addr", int'(addr[d]), snap_addr[d]);
          chk("hold_data", int'(data[d]), snap_data[d]);
        end
        rd = 1'b0;
        stall_left[d]--;
      end
      ready[d] = rd;
      if (v[d] && rd) begin
        chk("wr_in_range", int'(widx[d] < 5 * ncore(d)), 1);
        e = model(d, widx[d]);
        chk("wr_dst", dst_of(d), e.dst);
        chk("wr_addr", int'(addr[d]), e.addr);
        chk("wr_data", int'(data[d]), e.data);
        if (d == 1 && widx[d] == 14) chk("core3_cord", int'(data[d]), 32'h0201);
        widx[d]++; pend[d]++; nacc[d]++;
      end
    end
  endtask

  task automatic clear_model(int d);
    widx[d] = 0; pend[d] = 0; nacc[d] = 0; rel[d] = 0; spur[d] = 1'b0;
    resp_mode[d] = 0; rdy_mode[d] = 0; stall_at[d] = -1; stall_left[d] = 0;
  endtask

  task automatic chk_zero(int d, string tag);
    chk({tag, "_ctl"}, int'({v[d], busy[d], done[d], err[d], rrdy[d]}), 0);
    chk({tag, "_pay"}, dst_of(d) | int'(addr[d]) | int'(data[d]), 0);
  endtask

  task automatic do_reset(int d);
    @(negedge clk);
    rst_n[d] = 1'b0; start[d] = 1'b0; ready[d] = 1'b0; resp_v[d] = 1'b0;
    clear_model(d);
    repeat (2) @(negedge clk);
    rst_n[d] = 1'b1;
    cyc();
  endtask

  task automatic pulse_start(int d);
    start[d] = 1'b1;
    cyc();
    start[d] = 1'b0;
  endtask

  task automatic run_until_done(int d, int max_cyc);
    int n;
    n = 0;
    while (!done[d] && n < max_cyc) begin cyc(); n++; end
    chk("done_within_bound", int'(done[d]), 1);
  endtask

  task automatic run_until_widx(int d, int target, int max_cyc);
    int n;
    n = 0;
    while (widx[d] < target && n < max_cyc) begin cyc(); n++; end
    chk("reach_write_count", widx[d], target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0]  = mk(1, 0, 0, 0, 0, 0, 0,      0, 0);
    vec[1]  = mk(0, 1, 0, 1, 0, 1, 1,      1, 0);
    vec[2]  = mk(0, 1, 1, 1, 0, 2, 0,      1, 0);
    vec[3]  = mk(0, 1, 1, 1, 0, 3, 'h100,  1, 0);
    vec[4]  = mk(0, 1, 1, 1, 0, 4, 1,      1, 0);
    vec[5]  = mk(0, 1, 1, 1, 1, 1, 1,      1, 0);
    vec[6]  = mk(0, 1, 1, 1, 1, 2, 1,      1, 0);
    vec[7]  = mk(0, 1, 1, 1, 1, 3, 'h101,  1, 0);
    vec[8]  = mk(0, 1, 1, 1, 1, 4, 1,      1, 0);
    vec[9]  = mk(0, 1, 1, 0, 0, 0, 0,      1, 0);
    vec[10] = mk(0, 1, 0, 1, 0, 1, 0,      1, 0);
    vec[11] = mk(0, 1, 1, 1, 1, 1, 0,      1, 0);
    vec[12] = mk(0, 1, 1, 0, 0, 0, 0,      1, 0);
    vec[13] = mk(0, 1, 0, 0, 0, 0, 0,      0, 1);

    rst_n = '0; start = '0; ready = '0; resp_v = '0;
    clear_model(0); clear_model(1);
    repeat (3) @(negedge clk);
    chk_zero(0, "reset_a");
    chk_zero(1, "reset_b");
    rst_n = 2'b11;
    repeat (4) cyc();
    chk("resp_ready", int'(rrdy[0]), 1);

    // Directed N=2 run: start at the 5th cycle after reset, ready always,
    // every acknowledge one cycle after its write.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), int'({v[0], busy[0], done[0], err[0]}),
          int'({vec[i].v, vec[i].busy, vec[i].done, 1'b0}));
      if (vec[i].v) chk($sformatf("vec%0d_pay", i),
                        int'({dst_a, addr[0], data[0][15:0]}),
                        int'({vec[i].dst[0], vec[i].addr[15:0], vec[i].data[15:0]}));
      start[0] = vec[i].start; ready[0] = vec[i].rdy; resp_v[0] = vec[i].resp;
    end
    start[0] = 1'b0; ready[0] = 1'b0; resp_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("done_sticky", int'(done[0]), 1);

    // Withheld acknowledges: exactly four writes, then one more per release.
    do_reset(0);
    rdy_mode[0] = 1;
    pulse_start(0);
    repeat (20) cyc();
    chk("credit_limit_accepts", nacc[0], 4);
    chk("credit_limit_valid", int'(v[0]), 0);
    rel[0] = 1;
    repeat (10) cyc();
    chk("credit_release_accepts", nacc[0], 5);
    resp_mode[0] = 1;
    run_until_done(0, 200);
    chk("total_writes_a", widx[0], 10);
    chk("no_err_a", int'(err[0]), 0);

    // Back-pressure for 7 cycles on the third write.
    do_reset(0);
    rdy_mode[0] = 1; resp_mode[0] = 1; stall_at[0] = 2; stall_left[0] = 7;
    pulse_start(0);
    run_until_done(0, 200);
    chk("stall_applied", stall_left[0], 0);
    chk("stall_total_writes", widx[0], 10);
    stall_at[0] = -1;

    // Stray acknowledge in IDLE: sticky error, no writes, no counter wrap.
    do_reset(0);
    spur[0] = 1'b1;
    repeat (2) cyc();
    chk("spur_err", int'(err[0]), 1);
    chk("spur_idle", int'({v[0], busy[0]}), 0);
    repeat (3) cyc();
    chk("spur_err_sticky", int'(err[0]), 1);
    chk("spur_no_writes", nacc[0], 0);
    rdy_mode[0] = 1;
    pulse_start(0);
    repeat (15) cyc();
    chk("spur_credits_intact", nacc[0], 4);

    // Reset in the middle of pass 1, then a clean restart.
    do_reset(0);
    rdy_mode[0] = 1; resp_mode[0] = 1;
    pulse_start(0);
    run_until_widx(0, 2, 50);
    ready[0] = 1'b0; resp_v[0] = 1'b0;
    rst_n[0] = 1'b0;
    #1;
    chk_zero(0, "mid_reset");
    @(negedge clk);
    widx[0] = 0; pend[0] = 0; nacc[0] = 0;
    rst_n[0] = 1'b1;
    repeat (3) cyc();
    chk("after_reset_idle", int'({v[0], busy[0], done[0]}), 0);
    pulse_start(0);
    run_until_done(0, 200);
    chk("restart_total_writes", widx[0], 10);

    // 2x2 array, random ready/ack; start during DRAIN_CFG is ignored.
    rdy_mode[1] = 2; resp_mode[1] = 2;
    pulse_start(1);
    run_until_widx(1, 16, 2000);
    resp_mode[1] = 0;
    cyc();
    pulse_start(1);
    repeat (2) cyc();
    chk("drain_busy", int'(busy[1]), 1);
    chk("drain_no_valid", int'(v[1]), 0);
    chk("drain_no_extra", widx[1], 16);
    resp_mode[1] = 2;
    run_until_done(1, 2000);
    chk("total_writes_b", widx[1], 20);
    chk("no_err_b", int'(err[1]), 0);
    pulse_start(1);
    repeat (3) cyc();
    chk("done_ignores_start", int'({v[1], busy[1], done[1]}), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
